// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped output port: default register
// addresses, status bit positions and the status word packer.
package mmio_pkg;

    localparam logic [31:0] DEF_ADDR_DATA = 32'h0000_0100;
    localparam logic [31:0] DEF_ADDR_STAT = 32'h0000_0104;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

    function automatic logic [31:0] status_word(input logic       full,
                                                input logic       empty,
                                                input logic       ovf,
                                                input logic [3:0] cnt);
        logic [31:0] w;
        w                     = '0;
        w[ST_FULL]            = full;
        w[ST_EMPTY]           = empty;
        w[ST_OVF]             = ovf;
        w[ST_CNT_LSB +: 4]    = cnt;
        return w;
    endfunction

endpackage

// File: rtl/mmio_out_port_if.sv
// Data-memory bus slice plus outgoing byte stream of the output port.
// master = core/consumer side, slave = the port itself.
interface mmio_out_port_if;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] rdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    modport master (
        output mem_write, mem_read, addr, wdata, out_ready,
        input  hit, rdata, out_valid, out_data
    );

    modport slave (
        input  mem_write, mem_read, addr, wdata, out_ready,
        output hit, rdata, out_valid, out_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. The caller only asserts pop when
// not empty and push when not full or popping on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // DEPTH is a power of two, so plain pointer increment wraps correctly
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mmio_out_port.sv
// Memory-mapped TX port: address decode, sticky overflow flag, status read
// mux and push-accept rule around a byte FIFO drained by a valid/ready stream.
module mmio_out_port
    import mmio_pkg::*;
#(
    parameter logic [31:0] ADDR_DATA = DEF_ADDR_DATA,
    parameter logic [31:0] ADDR_STAT = DEF_ADDR_STAT,
    parameter int          DEPTH     = 4
) (
    input  logic             clk,
    input  logic             reset,
    mmio_out_port_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          sel_data;
    logic          sel_stat;
    logic          pop;
    logic          push;
    logic          ovf_set;
    logic          ovf;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [7:0]    dout;
    logic [3:0]    cnt4;
    logic          unused_wdata;

    assign sel_data = (bus.addr == ADDR_DATA);
    assign sel_stat = (bus.addr == ADDR_STAT);
    assign bus.hit  = sel_data | sel_stat;

    // A full FIFO still takes a store when the head leaves on the same edge
    assign pop     = !empty && bus.out_ready;
    assign push    = bus.mem_write && sel_data && (!full || pop);
    assign ovf_set = bus.mem_write && sel_data && full && !pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.wdata[7:0]),
        .dout  (dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            ovf <= 1'b0;
        else if (bus.mem_write && sel_stat)
            ovf <= 1'b0;
        else if (ovf_set)
            ovf <= 1'b1;
    end

    assign cnt4      = 4'(count);
    assign bus.rdata = (bus.mem_read && sel_stat) ? status_word(full, empty, ovf, cnt4)
                                                  : 32'h0;

    assign bus.out_valid = !empty;
    assign bus.out_data  = dout;

    assign unused_wdata = ^bus.wdata[31:8];

endmodule

// File: tb/tb_mmio_out_port.sv
// Randomised plus directed bench for mmio_out_port; byte order is checked by a
// negedge monitor against a queue filled by the stimulus-side reference model.
module tb_mmio_out_port;
    localparam int          DEPTH = 4;
    localparam logic [31:0] ADATA = 32'h0000_0100;
    localparam logic [31:0] ASTAT = 32'h0000_0104;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mmio_out_port_if bus();

    mmio_out_port #(
        .ADDR_DATA (ADATA),
        .ADDR_STAT (ASTAT),
        .DEPTH     (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         m_cnt = 0;
    bit         m_ovf = 1'b0;
    bit         known = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs, check combinational outputs against the
    // model's pre-edge view, then advance the model across the coming edge.
    task automatic step(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input bit rdy, input bit rst);
        logic [31:0] st;
        bit          pop;
        bit          acc;
        @(posedge clk);
        #1;
        bus.mem_write = w;
        bus.mem_read  = r;
        bus.addr      = a;
        bus.wdata     = d;
        bus.out_ready = rdy;
        reset         = rst;
        #1;
        if (known) begin
            st      = '0;
            st[7:4] = m_cnt[3:0];
            st[2]   = m_ovf;
            st[1]   = (m_cnt == 0);
            st[0]   = (m_cnt == DEPTH);
            check("hit", {31'b0, bus.hit}, {31'b0, (a == ADATA) || (a == ASTAT)});
            check("rdata", bus.rdata, (r && a == ASTAT) ? st : 32'h0);
            check("out_valid", {31'b0, bus.out_valid}, {31'b0, m_cnt != 0});
            if (m_cnt != 0)
                check("head", {24'b0, bus.out_data}, {24'b0, exp_q[0]});
        end
        if (!rst) begin
            exp_q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
            known = 1'b1;
        end else begin
            pop = (m_cnt != 0) && rdy;
            acc = 1'b0;
            if (w && a == ADATA) begin
                if (m_cnt < DEPTH || pop) acc = 1'b1;
                else                      m_ovf = 1'b1;
            end
            if (w && a == ASTAT) m_ovf = 1'b0;
            if (acc) exp_q.push_back(d[7:0]);
            m_cnt = m_cnt - int'(pop) + int'(acc);
        end
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 32'h0, 32'h0, rdy, 1'b1);
    endtask

    task automatic rd_stat();
        step(1'b0, 1'b1, ASTAT, 32'h0, 1'b0, 1'b1);
    endtask

    // Consumed bytes must match the order of accepted stores
    always @(negedge clk) begin
        if (known && reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_order: got %h with nothing expected at %0t", bus.out_data, $time);
            end else begin
                check("pop_order", {24'b0, bus.out_data}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [31:0] a;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.out_ready = 1'b0;

        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rd_stat();

        // single store, then one pop
        step(1'b1, 1'b0, ADATA, 32'hABCD_EF41, 1'b0, 1'b1);
        rd_stat();
        idle(1'b1);
        rd_stat();

        // overflow, drain, clear
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, ADATA, 32'(i), 1'b0, 1'b1);
        rd_stat();
        repeat (4) idle(1'b1);
        rd_stat();
        step(1'b1, 1'b0, ASTAT, 32'h0, 1'b0, 1'b1);
        rd_stat();

        // full plus simultaneous pop
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, ADATA, 32'(i), 1'b0, 1'b1);
        step(1'b1, 1'b0, ADATA, 32'h99, 1'b1, 1'b1);
        rd_stat();
        repeat (4) idle(1'b1);
        rd_stat();

        // streaming with wrap
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, ADATA, 32'h10 + 32'(i), 1'b1, 1'b1);
        repeat (2) idle(1'b1);

        // reset mid-operation with a store on the reset edge
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, ADATA, 32'h30 + 32'(i), 1'b0, 1'b1);
        step(1'b1, 1'b0, ADATA, 32'h77, 1'b0, 1'b0);
        rd_stat();
        step(1'b1, 1'b0, 32'h0000_00FC, 32'h55, 1'b0, 1'b1);
        rd_stat();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0:       a = ADATA;
                1:       a = ASTAT;
                2:       a = 32'h0000_00FC;
                default: a = $urandom;
            endcase
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 79) != 0));
        end

        repeat (8) idle(1'b1);
        check("drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
